// File: rtl/bsg_dfi_fifo_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_dfi_fifo_cmd_decoder
//  Function : Decodes captured DFI commands into word-level memory requests,
//             tracks per-bank open rows and returns read bursts through a
//             credit-limited read buffer.
//             Optional macro: BSG_DFI_DECODE_BANK_CHECK_EN (bank-state check).
//  Revision : 1.0  initial release
// ============================================================================
module bsg_dfi_fifo_cmd_decoder #(
    parameter  int dq_data_width_p   = 32,
    parameter  int burst_len_p       = 2,
    parameter  int col_width_p       = 10,
    parameter  int row_width_p       = 16,
    parameter  int rd_credits_p      = 2,
    localparam int mem_addr_width_lp = 3 + row_width_p + col_width_p
) (
    input  logic                                               clk_i,
    input  logic                                               reset_n_i,
    input  logic                                               cmd_v_i,
    input  logic [25:0]                                        cmd_data_i,
    output logic                                               cmd_yumi_o,
    input  logic                                               wr_v_i,
    input  logic [2*dq_data_width_p+2*(dq_data_width_p>>3)-1:0] wr_data_i,
    output logic                                               wr_yumi_o,
    output logic                                               mem_v_o,
    output logic                                               mem_w_o,
    output logic [mem_addr_width_lp-1:0]                       mem_addr_o,
    output logic [2*dq_data_width_p-1:0]                       mem_data_o,
    output logic [2*(dq_data_width_p>>3)-1:0]                  mem_mask_o,
    input  logic                                               mem_ready_i,
    input  logic                                               mem_resp_v_i,
    input  logic [2*dq_data_width_p-1:0]                       mem_resp_data_i,
    output logic                                               rd_v_o,
    output logic [2*dq_data_width_p-1:0]                       rd_data_o,
    input  logic                                               rd_ready_i,
    output logic                                               error_o
);

    localparam int c_DATA_W = 2 * dq_data_width_p;
    localparam int c_MASK_W = 2 * (dq_data_width_p >> 3);
    localparam int c_BEAT_W = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
    localparam int c_PTR_W  = (rd_credits_p > 1) ? $clog2(rd_credits_p) : 1;
    localparam int c_CRED_W = $clog2(rd_credits_p + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_e;

    state_e r_state;
    state_e w_state_n;

    // Command field extraction
    logic [2:0]  w_bank;
    logic [15:0] w_addr;
    logic        w_cs_n;
    logic [2:0]  w_op;
    logic        w_is_act, w_is_pre, w_is_rd, w_is_wr;

    assign w_bank   = cmd_data_i[25:23];
    assign w_addr   = cmd_data_i[22:7];
    assign w_cs_n   = cmd_data_i[5];
    assign w_op     = cmd_data_i[4:2];
    assign w_is_act = ~w_cs_n & (w_op == 3'b011);
    assign w_is_pre = ~w_cs_n & (w_op == 3'b010);
    assign w_is_rd  = ~w_cs_n & (w_op == 3'b101);
    assign w_is_wr  = ~w_cs_n & (w_op == 3'b100);

    // Bank state and burst context
    logic [7:0]             r_bank_open;
    logic [row_width_p-1:0] r_bank_row [0:7];
    logic [2:0]             r_bank;
    logic [row_width_p-1:0] r_row;
    logic [col_width_p-1:0] r_col;
    logic [c_BEAT_W-1:0]    r_beat;
    logic [c_CRED_W-1:0]    r_credits;

    // Read buffer
    logic [c_DATA_W-1:0]    r_rdbuf [0:rd_credits_p-1];
    logic [c_PTR_W-1:0]     r_rd_wptr, r_rd_rptr;
    logic [c_CRED_W-1:0]    r_rd_count;
    logic                   r_error;

    logic w_cmd_yumi, w_mem_v, w_mem_w, w_wr_yumi;
    logic w_act_fire, w_pre_fire, w_burst_start, w_beat_inc, w_req;
    logic w_last, w_empty, w_full, w_enq, w_deq, w_ovf, w_bank_err;
    logic [col_width_p-1:0] w_beat_ext, w_col;

    assign w_last     = (r_beat == c_BEAT_W'(burst_len_p - 1));
    assign w_beat_ext = col_width_p'(r_beat);
    // Column wraps inside the row; it never carries into the row field.
    assign w_col      = r_col + w_beat_ext;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_cmd_yumi    = 1'b0;
        w_mem_v       = 1'b0;
        w_mem_w       = 1'b0;
        w_wr_yumi     = 1'b0;
        w_act_fire    = 1'b0;
        w_pre_fire    = 1'b0;
        w_burst_start = 1'b0;
        w_beat_inc    = 1'b0;
        w_req         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_v_i) begin
                    if (w_is_wr) begin
                        w_state_n     = ST_WRITE;
                        w_burst_start = 1'b1;
                    end else if (w_is_rd) begin
                        w_state_n     = ST_READ;
                        w_burst_start = 1'b1;
                    end else begin
                        w_cmd_yumi = 1'b1;
                        w_act_fire = w_is_act;
                        w_pre_fire = w_is_pre;
                    end
                end
            end
            ST_WRITE: begin
                w_mem_v = wr_v_i;
                w_mem_w = 1'b1;
                if (mem_ready_i && wr_v_i) begin
                    w_wr_yumi  = 1'b1;
                    w_beat_inc = 1'b1;
                    if (w_last) begin
                        w_cmd_yumi = cmd_v_i;
                        w_state_n  = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                w_mem_v = (r_credits != '0);
                if (w_mem_v && mem_ready_i) begin
                    w_req      = 1'b1;
                    w_beat_inc = 1'b1;
                    if (w_last) begin
                        w_cmd_yumi = cmd_v_i;
                        w_state_n  = ST_IDLE;
                    end
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // RD/WR are held at the FIFO head during the burst, so ACT/PRE only act in IDLE.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_bank_open <= '0;
            for (int i = 0; i < 8; i++) begin
                r_bank_row[i] <= '0;
            end
        end else begin
            if (w_act_fire) begin
                r_bank_open[w_bank] <= 1'b1;
                r_bank_row[w_bank]  <= w_addr[row_width_p-1:0];
            end
            if (w_pre_fire) begin
                if (w_addr[10]) begin
                    r_bank_open <= '0;
                end else begin
                    r_bank_open[w_bank] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_bank <= '0;
            r_row  <= '0;
            r_col  <= '0;
            r_beat <= '0;
        end else if (w_burst_start) begin
            r_bank <= w_bank;
            r_row  <= r_bank_row[w_bank];
            r_col  <= w_addr[col_width_p-1:0];
            r_beat <= '0;
        end else if (w_beat_inc) begin
            r_beat <= r_beat + 1'b1;
        end
    end

`ifdef BSG_DFI_DECODE_BANK_CHECK_EN
    assign w_bank_err = (r_state == ST_IDLE) & cmd_v_i &
                        ((((w_is_rd | w_is_wr) & ~r_bank_open[w_bank])) |
                         (w_is_act & r_bank_open[w_bank]));
`else
    assign w_bank_err = 1'b0;
`endif

    function automatic logic [c_PTR_W-1:0] f_ptr_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(rd_credits_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_empty = (r_rd_count == '0);
    assign w_full  = (r_rd_count == c_CRED_W'(rd_credits_p));
    assign w_deq   = ~w_empty & rd_ready_i;
    // A slot freed by a same-cycle dequeue can take the incoming response.
    assign w_enq   = mem_resp_v_i & (~w_full | w_deq);
    assign w_ovf   = mem_resp_v_i & w_full & ~w_deq;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_wptr  <= '0;
            r_rd_rptr  <= '0;
            r_rd_count <= '0;
            r_credits  <= c_CRED_W'(rd_credits_p);
            r_error    <= 1'b0;
        end else begin
            if (w_enq) begin
                r_rd_wptr <= f_ptr_next(r_rd_wptr);
            end
            if (w_deq) begin
                r_rd_rptr <= f_ptr_next(r_rd_rptr);
            end
            case ({w_enq, w_deq})
                2'b10:   r_rd_count <= r_rd_count + 1'b1;
                2'b01:   r_rd_count <= r_rd_count - 1'b1;
                default: r_rd_count <= r_rd_count;
            endcase
            case ({w_req, w_deq})
                2'b10:   r_credits <= r_credits - 1'b1;
                2'b01:   r_credits <= r_credits + 1'b1;
                default: r_credits <= r_credits;
            endcase
            r_error <= r_error | w_ovf | w_bank_err;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_rdbuf[r_rd_wptr] <= mem_resp_data_i;
        end
    end

    logic w_unused;
    assign w_unused = ^{cmd_data_i[6], cmd_data_i[1:0], w_addr, r_bank_open};

    assign cmd_yumi_o = w_cmd_yumi & reset_n_i;
    assign wr_yumi_o  = w_wr_yumi;
    assign mem_v_o    = w_mem_v;
    assign mem_w_o    = w_mem_w;
    assign mem_addr_o = {r_bank, r_row, w_col};
    assign mem_data_o = (r_state == ST_WRITE) ? wr_data_i[c_DATA_W+c_MASK_W-1:c_MASK_W] : '0;
    assign mem_mask_o = (r_state == ST_WRITE) ? wr_data_i[c_MASK_W-1:0] : '0;
    assign rd_v_o     = ~w_empty;
    assign rd_data_o  = w_empty ? '0 : r_rdbuf[r_rd_rptr];
    assign error_o    = r_error;

endmodule
`default_nettype wire

// File: doc/bsg_dfi_fifo_cmd_decoder.md
Name: bsg_dfi_fifo_cmd_decoder

Overview:
Sits downstream of the DFI-to-FIFO bridge in the fifo clock domain. It consumes the captured DFI command, write-data and read-data FIFO streams and turns DDR column commands into word-level memory requests. It returns read bursts to the bridge's read-data FIFO. It also tracks per-bank open rows, so memory addresses are formed as {bank,row,col}.

Parameters:
dq_data_width_p, 32, DFI DQ width; one FIFO beat is 2*dq_data_width_p data bits plus 2*(dq_data_width_p>>3) mask bits
burst_len_p, 2, FIFO beats per RD/WR command; must be a power of two, at least 1
col_width_p, 10, column bits taken from dfi address[col_width_p-1:0]
row_width_p, 16, row bits latched from dfi address at ACT
rd_credits_p, 2, maximum outstanding memory reads; equals read buffer depth
mem_addr_width_lp, derived, 3+row_width_p+col_width_p

Ports:
clk_i  in  1  fifo clock
reset_n_i  in  1  asynchronous active-low reset
cmd_v_i  in  1  command FIFO valid
cmd_data_i  in  26  {bank[2:0],addr[15:0],cke,cs_n,ras_n,cas_n,we_n,reset_n,odt}
cmd_yumi_o  out  1  command consumed
wr_v_i  in  1  write-data FIFO valid
wr_data_i  in  2*dq+2*dq/8  {data,mask}
wr_yumi_o  out  1  write beat consumed
mem_v_o  out  1  memory request valid
mem_w_o  out  1  1=write, 0=read
mem_addr_o  out  mem_addr_width_lp  {bank,row,col+beat}
mem_data_o  out  2*dq  write data
mem_mask_o  out  2*dq/8  write mask, 1=byte masked
mem_ready_i  in  1  memory accepts request
mem_resp_v_i  in  1  read response valid, in order, never back-pressured
mem_resp_data_i  in  2*dq  read response data
rd_v_o  out  1  read data valid toward bridge
rd_data_o  out  2*dq  read data
rd_ready_i  in  1  bridge accepts read beat
error_o  out  1  sticky protocol error

Behaviour:
- Reset: all outputs 0. FSM is IDLE. All banks are closed. Credits equal rd_credits_p. Read buffer is empty.
- Decode, only when cs_n=0, using {ras_n,cas_n,we_n}: 011 ACT, 010 PRE (addr[10]=1 means all banks), 101 RD, 100 WR, 001 REF, 000 MRS, 111 NOP, 110 ZQ.
- cs_n=1 entries, NOP, REF, MRS and ZQ: consumed in 1 cycle with no effect.
- IDLE with cmd_v_i:
  - ACT: open bank, latch row = addr[row_width_p-1:0], set cmd_yumi_o in the same cycle.
  - PRE: close the addressed bank, or all banks; cmd_yumi_o in the same cycle.
  - WR: latch bank/row/col, beat counter = 0, go to WRITE. cmd_yumi_o fires on the last beat, not at entry.
  - RD: latch bank/row/col, go to READ.
- WRITE:
  - mem_v_o=wr_v_i, mem_w_o=1, data/mask driven from wr_data_i.
  - On mem_ready_i & wr_v_i: wr_yumi_o=1, beat counter +1.
  - Last beat: cmd_yumi_o=1, return to IDLE.
- READ:
  - mem_v_o = (credits != 0), mem_w_o=0.
  - Each accepted request decrements credits and increments the beat counter.
  - Last accepted beat: cmd_yumi_o=1, return to IDLE.
- Column arithmetic: col + beat, modulo 2^col_width_p. Wraps and never carries into the row.
- Read path:
  - mem_resp_v_i is written into a FIFO of depth rd_credits_p.
  - rd_v_o = FIFO not empty; dequeue on rd_v_o & rd_ready_i.
  - Each dequeue returns one credit. A same-cycle dequeue and request nets a credit change of 0.
- Latency: IDLE-to-request is 1 cycle after cmd capture. Response to rd_v_o is 1 cycle.
- FIFO ready/valid conventions: *_yumi_o is asserted only when the matching *_v_i is high.
- Reset asserted mid-burst: everything aborts immediately. Partially consumed bursts are not replayed.
- A response arriving while the buffer is full cannot occur under credit rules; if it does, set error_o.

Optional Feature:
BSG_DFI_DECODE_BANK_CHECK_EN
- Defined: RD/WR to a closed bank, or ACT to an open bank, sets error_o (sticky until reset). The command is still executed, using the stale row for RD/WR.
- Undefined: no bank check is made; error_o reports only read-buffer overflow.

Test Plan:
- ACT bank 2 row 0x1234, then WR col 0x008 with 2 beats, mem_ready_i=1 -> two writes at {2,0x1234,0x008} and {2,0x1234,0x009}, two wr_yumi_o pulses, cmd_yumi_o on the 2nd beat.
- ACT bank 0 row 5, RD col 0x3FF, mem_resp returns 2 beats, rd_ready_i=0 -> read addresses col 0x3FF then 0x000 (wrap); rd_v_o held, no 3rd request until a credit frees.
- Back-to-back RDs with rd_ready_i toggling 1/0 -> at most 2 outstanding, data order preserved, no error.
- PRE with addr[10]=1, then WR bank 3 (check enabled) -> error_o=1 and stays 1; with check disabled, error_o=0.
- Stream of cs_n=1 and REF entries -> one cmd_yumi_o per entry, mem_v_o never asserted.
- reset_n_i pulled low mid-WRITE -> all outputs 0 asynchronously; after release, first WR issues to row 0.
